alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
Round-robin scheduler that shares one combinational 7-bit ALU (4-bit opcode, result/carry/zero outputs) between two requesters.
- Accepts operation requests over per-requester valid/ready handshakes.
- Drives registered operands to the ALU and captures its outputs.
- Returns each response to its owning requester over a valid/ready handshake.
- Sits between the register-file/sequencer clients and the shared ALU instance.

Parameters:
DW, 7, operand/result width; must match the ALU.
OPW, 4, opcode width.
DIV_OP, 4'b1111, opcode treated as divide for the divide-by-zero error flag.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  2  request valid, bit i = requester i.
req_ready  out  2  request accepted this cycle, bit i = requester i.
req0_a, req0_b  in  DW  requester 0 operands.
req0_op  in  OPW  requester 0 opcode.
req1_a, req1_b  in  DW  requester 1 operands.
req1_op  in  OPW  requester 1 opcode.
rsp_valid  out  2  response valid for requester i.
rsp_ready  in  2  requester i takes its response.
rsp_result  out  DW  captured ALU result.
rsp_carry  out  1  captured ALU carry.
rsp_zero  out  1  captured ALU zero flag.
rsp_err  out  1  divide-by-zero flag (op==DIV_OP and b==0).
alu_a, alu_b  out  DW  registered operands to the ALU.
alu_op  out  OPW  registered opcode to the ALU.
alu_result  in  DW  ALU result.
alu_carry  in  1  ALU carry.
alu_zero  in  1  ALU zero flag.

Behaviour:
- FSM states:
  - IDLE: at least one req_valid bit set -> choose grant; assert req_ready[grant] combinationally for that cycle; latch that requester's a/b/op into alu_a/alu_b/alu_op; record owner; go to EXEC. No valid -> stay in IDLE.
  - EXEC: the ALU settles on the registered operands. At the clock edge capture alu_result/alu_carry/alu_zero into rsp_*; set rsp_err = (alu_op==DIV_OP && alu_b==0); go to RESP.
  - RESP: rsp_valid[owner]=1, other bit 0. When rsp_ready[owner]=1: go to IDLE, last_grant<=owner. Otherwise hold and keep all rsp_* stable.
- Arbitration:
  - Only one valid -> grant it.
  - Both valid -> grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- req_ready is 0 in EXEC and RESP. Requests arriving then wait; requesters must hold valid and operands stable until ready.
- req_ready is at most one-hot and only in IDLE.
- Latency: accept at edge T -> rsp_valid high from T+2. Minimum 3 cycles per op (accept, exec, respond with rsp_ready already high).
- rsp_ready on a non-owner bit is ignored.
- alu_a/alu_b/alu_op hold their values through RESP and after returning to IDLE until the next grant.
- Arithmetic and width behaviour is entirely the ALU's. The scheduler passes DW-bit values unmodified and does not alter rsp_zero.
- Reset (rst_n=0 at an edge), from any state:
  - Go to IDLE.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_op=0, last_grant=1.
  - An in-flight response is discarded.
- Reset mid-RESP: rsp_valid drops in the cycle after the reset edge, and no response is ever delivered for that op.

Optional Feature:
ALU_SCHED_STATS_EN
- Defined:
  - Adds outputs stat_grant0 and stat_grant1 (8 bits each), counting accepted requests per requester.
  - Counters saturate at 8'hFF and never wrap.
  - Cleared by rst_n.
  - Adds output stat_conflict (8 bits, saturating), counting IDLE cycles with both req_valid bits set when a grant is issued.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset then req_valid=2'b01, a=7'd5, b=7'd3, op=4'b0000, rsp_ready=2'b01 held -> req_ready=01 in the grant cycle; rsp_valid=01 exactly 2 cycles later; rsp_result=8, carry=0, zero=0; back in IDLE next cycle.
- Both valid from reset: r0 op=0001 a=9 b=9; r1 op=0010 a=7'h0F b=7'h33 -> r0 granted first (result 0, zero=1); then r1 (result 7'h03); then r0 again if still valid (alternation).
- r1 request op=4'b1111 a=7'd20 b=0 -> rsp_result=20, rsp_err=1, rsp_valid=2'b10.
- Hold rsp_ready=0 for 5 cycles in RESP while the other requester is valid -> rsp_* stable, req_ready stays 00; response released on rsp_ready; other requester granted in the following IDLE cycle.
- rst_n=0 for one cycle while in RESP -> next cycle rsp_valid=00, all outputs 0, last_grant=1; a subsequent tie grants r0.
- With ALU_SCHED_STATS_EN: 300 back-to-back r0-only ops -> stat_grant0=8'hFF, stat_grant1=0, stat_conflict=0.

Source files
------------

// File: rtl/alu_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_rr_sched_if
// Brief   : Request/response and shared-ALU signal bundle for alu_rr_sched.
//           slave = scheduler view, master = requesters plus ALU view.
//           ALU_SCHED_STATS_EN adds the grant/conflict statistic outputs.
// Rev     : 1.0  initial release
// ============================================================================
interface alu_rr_sched_if #(
   parameter int DW  = 7,
   parameter int OPW = 4
);
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [DW-1:0]  req0_a;
   logic [DW-1:0]  req0_b;
   logic [OPW-1:0] req0_op;
   logic [DW-1:0]  req1_a;
   logic [DW-1:0]  req1_b;
   logic [OPW-1:0] req1_op;

   logic [1:0]     rsp_valid;
   logic [1:0]     rsp_ready;
   logic [DW-1:0]  rsp_result;
   logic           rsp_carry;
   logic           rsp_zero;
   logic           rsp_err;

   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [OPW-1:0] alu_op;
   logic [DW-1:0]  alu_result;
   logic           alu_carry;
   logic           alu_zero;

`ifdef ALU_SCHED_STATS_EN
   logic [7:0]     stat_grant0;
   logic [7:0]     stat_grant1;
   logic [7:0]     stat_conflict;
`endif

   modport slave (
      input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
      output req_ready,
      output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
      input  rsp_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_carry, alu_zero
`ifdef ALU_SCHED_STATS_EN
      ,
      output stat_grant0, stat_grant1, stat_conflict
`endif
   );

   modport master (
      output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
      input  req_ready,
      input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
      output rsp_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_carry, alu_zero
`ifdef ALU_SCHED_STATS_EN
      ,
      input  stat_grant0, stat_grant1, stat_conflict
`endif
   );
endinterface
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : alu_rr_sched
// Brief   : Two-requester round-robin scheduler in front of one shared
//           combinational ALU (IDLE -> EXEC -> RESP per operation).
//           Optional macro ALU_SCHED_STATS_EN adds saturating statistics.
// Rev     : 1.0  initial release
// ============================================================================
module alu_rr_sched #(
   parameter int             DW     = 7,
   parameter int             OPW    = 4,
   parameter logic [OPW-1:0] DIV_OP = 4'b1111
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_rr_sched_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [1:0]     w_req_ready;
   logic [1:0]     w_rsp_valid;
   logic           w_grant;
   logic           w_accept;
   logic           w_release;
   logic           w_div_zero;

   logic           r_owner;
   logic           r_last_grant;
   logic [DW-1:0]  r_alu_a;
   logic [DW-1:0]  r_alu_b;
   logic [OPW-1:0] r_alu_op;
   logic [DW-1:0]  r_rsp_result;
   logic           r_rsp_carry;
   logic           r_rsp_zero;
   logic           r_rsp_err;

   // On a tie the requester that was not served last wins.
   always_comb begin
      case (bus.req_valid)
         2'b01:   w_grant = 1'b0;
         2'b10:   w_grant = 1'b1;
         2'b11:   w_grant = ~r_last_grant;
         default: w_grant = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 2'b00;
      w_rsp_valid = 2'b00;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rst_n && (|bus.req_valid)) begin
               w_accept             = 1'b1;
               w_req_ready[w_grant] = 1'b1;
               w_state_nxt          = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_rsp_valid[r_owner] = 1'b1;
            if (bus.rsp_ready[r_owner]) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_div_zero = (r_alu_op == DIV_OP) && (r_alu_b == '0);

   // Operands stay on the ALU until the next grant; results are frozen in RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_rsp_result <= '0;
         r_rsp_carry  <= 1'b0;
         r_rsp_zero   <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_owner  <= w_grant;
            r_alu_a  <= w_grant ? bus.req1_a  : bus.req0_a;
            r_alu_b  <= w_grant ? bus.req1_b  : bus.req0_b;
            r_alu_op <= w_grant ? bus.req1_op : bus.req0_op;
         end
         if (r_state == S_EXEC) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_carry  <= bus.alu_carry;
            r_rsp_zero   <= bus.alu_zero;
            r_rsp_err    <= w_div_zero;
         end
         if (w_release) begin
            r_last_grant <= r_owner;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_carry  = r_rsp_carry;
   assign bus.rsp_zero   = r_rsp_zero;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_op     = r_alu_op;

`ifdef ALU_SCHED_STATS_EN
   logic [7:0] r_stat_grant0;
   logic [7:0] r_stat_grant1;
   logic [7:0] r_stat_conflict;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_grant0   <= 8'd0;
         r_stat_grant1   <= 8'd0;
         r_stat_conflict <= 8'd0;
      end else if (w_accept) begin
         if (!w_grant && (r_stat_grant0 != 8'hFF)) begin
            r_stat_grant0 <= r_stat_grant0 + 8'd1;
         end
         if (w_grant && (r_stat_grant1 != 8'hFF)) begin
            r_stat_grant1 <= r_stat_grant1 + 8'd1;
         end
         if ((&bus.req_valid) && (r_stat_conflict != 8'hFF)) begin
            r_stat_conflict <= r_stat_conflict + 8'd1;
         end
      end
   end

   assign bus.stat_grant0   = r_stat_grant0;
   assign bus.stat_grant1   = r_stat_grant1;
   assign bus.stat_conflict = r_stat_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_rr_sched
// Brief   : Scoreboard bench for alu_rr_sched with a behavioural ALU and an
//           arbitration/latency reference model (ALU_SCHED_STATS_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_rr_sched;
   localparam int             DW       = 7;
   localparam int             OPW      = 4;
   localparam logic [OPW-1:0] C_DIV_OP = 4'b1111;

   typedef struct packed {
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [OPW-1:0] op;
      logic [DW-1:0]  res;
      logic           c;
      logic           z;
      logic           err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t q0[$];
   exp_t q1[$];
   logic [1:0] acc_pend = 2'b00;

   alu_rr_sched_if #(.DW(DW), .OPW(OPW)) bus ();

   alu_rr_sched #(.DW(DW), .OPW(OPW), .DIV_OP(C_DIV_OP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {carry, result}; divide by zero passes a through.
   function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OPW-1:0] op);
      logic [DW:0] r;
      case (op)
         4'd0:    r = {1'b0, a} + {1'b0, b};
         4'd1:    r = {1'b0, a} - {1'b0, b};
         4'd2:    r = {1'b0, a & b};
         4'd3:    r = {1'b0, a | b};
         4'd4:    r = {1'b0, a ^ b};
         4'd15:   r = (b == '0) ? {1'b0, a} : {1'b0, a / b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   logic [DW:0] w_alu;
   assign w_alu          = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.alu_result = w_alu[DW-1:0];
   assign bus.alu_carry  = w_alu[DW];
   assign bus.alu_zero   = (w_alu[DW-1:0] == '0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OPW-1:0] op);
      exp_t        e;
      logic [DW:0] r;
      r     = alu_fn(a, b, op);
      e.a   = a;
      e.b   = b;
      e.op  = op;
      e.res = r[DW-1:0];
      e.c   = r[DW];
      e.z   = (r[DW-1:0] == '0);
      e.err = (op == C_DIV_OP) && (b == '0);
      if (i == 0) begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
         q0.push_back(e);
         bus.req_valid[0] = 1'b1;
      end else begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
         q1.push_back(e);
         bus.req_valid[1] = 1'b1;
      end
   endtask

   function automatic logic [OPW-1:0] rand_op();
      int unsigned p;
      p = $urandom_range(0, 7);
      if (p <= 4) return OPW'(p);
      if (p <= 6) return C_DIV_OP;
      return OPW'($urandom_range(0, 15));
   endfunction

   function automatic logic [DW-1:0] rand_b();
      if ($urandom_range(0, 3) == 0) return '0;
      return DW'($urandom);
   endfunction

   task automatic issue_rand(input int i);
      issue(i, DW'($urandom), rand_b(), rand_op());
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (acc_pend[i]) begin
            bus.req_valid[i] = 1'b0;
            acc_pend[i]      = 1'b0;
         end
      end
   endtask

   task automatic end_cycle(input logic [1:0] rdy);
      bus.rsp_ready = rdy;
      #1;
      for (int i = 0; i < 2; i++) begin
         if (bus.req_ready[i]) acc_pend[i] = 1'b1;
      end
   endtask

   task automatic idle_cycles(input int n, input logic [1:0] rdy);
      for (int k = 0; k < n; k++) begin
         begin_cycle();
         end_cycle(rdy);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (((bus.req_valid != 2'b00) || (q0.size() != 0) || (q1.size() != 0)) && (k < 200)) begin
         begin_cycle();
         end_cycle(2'b11);
         k++;
      end
      idle_cycles(1, 2'b11);
      chk("drain_pending", {q0.size() != 0, q1.size() != 0}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      acc_pend      = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- reference model / monitor ----------------
   logic           m_busy  = 1'b0;
   int             m_age   = 0;
   logic           m_owner = 1'b0;
   logic           m_last  = 1'b1;
   logic           m_post  = 1'b0;
   logic [DW-1:0]  m_alu_a = '0;
   logic [DW-1:0]  m_alu_b = '0;
   logic [OPW-1:0] m_alu_op = '0;
   int             m_g0 = 0, m_g1 = 0, m_cf = 0;

   always @(negedge clk) begin
      logic [1:0] exp_rr;
      logic [1:0] exp_rv;
      logic       g;
      logic       have;
      exp_t       h;
      #2;
      if (!rst_n) begin
         m_busy = 1'b0; m_last = 1'b1; m_post = 1'b1;
         m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
         m_g0 = 0; m_g1 = 0; m_cf = 0;
         q0.delete();
         q1.delete();
      end else begin
         if (m_post) begin
            chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
            chk("rst_rsp_result", bus.rsp_result, 0);
            chk("rst_rsp_flags", {bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 0);
            chk("rst_alu_regs", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
            m_post = 1'b0;
         end
         if (m_busy) m_age++;

         exp_rr = 2'b00;
         g      = 1'b0;
         if (!m_busy && (bus.req_valid != 2'b00)) begin
            if (bus.req_valid == 2'b01)      g = 1'b0;
            else if (bus.req_valid == 2'b10) g = 1'b1;
            else                             g = ~m_last;
            exp_rr[g] = 1'b1;
         end
         chk("req_ready", bus.req_ready, exp_rr);
         chk("alu_operands", {bus.alu_a, bus.alu_b, bus.alu_op}, {m_alu_a, m_alu_b, m_alu_op});

         exp_rv = 2'b00;
         if (m_busy && (m_age >= 2)) exp_rv[m_owner] = 1'b1;
         chk("rsp_valid", bus.rsp_valid, exp_rv);

         if (m_busy && (m_age >= 2)) begin
            have = (m_owner == 1'b0) ? (q0.size() != 0) : (q1.size() != 0);
            chk("sb_entry_present", have, 1'b1);
            if (have) begin
               h = (m_owner == 1'b0) ? q0[0] : q1[0];
               chk("rsp_result", bus.rsp_result, h.res);
               chk("rsp_carry", bus.rsp_carry, h.c);
               chk("rsp_zero", bus.rsp_zero, h.z);
               chk("rsp_err", bus.rsp_err, h.err);
            end
            if (bus.rsp_ready[m_owner]) begin
               if (have) begin
                  if (m_owner == 1'b0) void'(q0.pop_front());
                  else                 void'(q1.pop_front());
               end
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end

         if (exp_rr != 2'b00) begin
            have = (g == 1'b0) ? (q0.size() != 0) : (q1.size() != 0);
            if (have) begin
               h = (g == 1'b0) ? q0[0] : q1[0];
               m_alu_a = h.a; m_alu_b = h.b; m_alu_op = h.op;
            end
            m_busy  = 1'b1;
            m_age   = 0;
            m_owner = g;
            if (g == 1'b0) m_g0 = (m_g0 < 255) ? m_g0 + 1 : 255;
            else           m_g1 = (m_g1 < 255) ? m_g1 + 1 : 255;
            if (bus.req_valid == 2'b11) m_cf = (m_cf < 255) ? m_cf + 1 : 255;
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      do_reset();

      // single r0 add, rsp_ready held
      begin_cycle(); issue(0, 7'd5, 7'd3, 4'b0000); end_cycle(2'b01);
      idle_cycles(4, 2'b01);

      // tie from reset, then alternation with r0 re-requesting
      begin_cycle(); issue(0, 7'd9, 7'd9, 4'b0001); issue(1, 7'h0F, 7'h33, 4'b0010); end_cycle(2'b11);
      for (int k = 0; k < 12; k++) begin
         begin_cycle();
         if (!bus.req_valid[0] && (k < 6)) issue(0, 7'd9, 7'd9, 4'b0001);
         end_cycle(2'b11);
      end
      drain();

      // r1 divide by zero
      begin_cycle(); issue(1, 7'd20, 7'd0, 4'b1111); end_cycle(2'b10);
      drain();

      // response held while the other requester waits
      begin_cycle(); issue(0, 7'd100, 7'd50, 4'b0000); end_cycle(2'b00);
      begin_cycle(); issue(1, 7'd77, 7'd7, 4'b1111); end_cycle(2'b00);
      idle_cycles(6, 2'b10);
      idle_cycles(1, 2'b01);
      drain();

      // reset in RESP, then a tie must go to r0
      begin_cycle(); issue(1, 7'd33, 7'd2, 4'b0001); end_cycle(2'b00);
      idle_cycles(3, 2'b00);
      do_reset();
      begin_cycle(); issue(0, 7'd1, 7'd2, 4'b0011); issue(1, 7'd3, 7'd4, 4'b0100); end_cycle(2'b11);
      drain();

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         begin_cycle();
         for (int i = 0; i < 2; i++) begin
            if (!bus.req_valid[i] && ($urandom_range(0, 2) == 0)) issue_rand(i);
         end
         end_cycle(2'($urandom_range(0, 3)));
      end
      drain();

`ifdef ALU_SCHED_STATS_EN
      do_reset();
      for (int k = 0; k < 300; k++) begin
         int w;
         w = 0;
         while (bus.req_valid[0] && (w < 20)) begin
            begin_cycle();
            end_cycle(2'b01);
            w++;
         end
         begin_cycle(); issue_rand(0); end_cycle(2'b01);
      end
      drain();
      chk("stat_grant0", bus.stat_grant0, m_g0[7:0]);
      chk("stat_grant1", bus.stat_grant1, m_g1[7:0]);
      chk("stat_conflict", bus.stat_conflict, m_cf[7:0]);
      chk("stat_grant0_sat", bus.stat_grant0, 8'hFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
